tone_burst_gen: RTL and testbench
=================================

# tone_burst_gen

Downstream consumer of the binary-counter tick. It turns each rising edge of the counter's match output into a half-period step of a square wave. The wave is emitted as a programmable number of tone bursts, separated by silent gaps measured in ticks. A start/busy/done handshake lets the lab's top-level control logic trigger a burst sequence and observe when it has completed.

## Interface
- W, 16: width of half_periods, gap_ticks and their internal counters
- R, 4: width of bursts and the burst counter

- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous reset, active-high
- tick  input  1  match output of upstream counter; only rising edges count
- start  input  1  request a sequence; sampled only in IDLE
- stop  input  1  synchronous abort, any state
- half_periods  input  W  wave toggles per burst; latched on accepted start
- bursts  input  R  number of bursts; latched on accepted start
- gap_ticks  input  W  silent tick events between bursts; latched on accepted start
- wave  output  1  square-wave audio output
- busy  output  1  high while a sequence is active
- done  output  1  one-cycle pulse on normal completion

## Operation
- Tick event: tick=1 while registered tick_q=0. tick_q resets to 0 and updates every cycle in every state. A tick held high for N cycles counts as one event.
- States: IDLE, TONE, GAP. State and all outputs are registered.
- IDLE: wave=0, busy=0.
  - start=1 with half_periods≠0 and bursts≠0: latch all three inputs, clear hp_cnt, burst_cnt and gap_cnt, then go to TONE.
  - start=1 with half_periods=0 or bursts=0: pulse done next cycle, stay IDLE, busy stays 0.
  - A tick event in the same cycle as an accepted start is not counted.
- TONE: each tick event toggles wave and increments hp_cnt.
  - When the incremented hp_cnt equals the latched half_periods, increment burst_cnt.
  - If burst_cnt then equals the latched bursts: go to IDLE, force wave=0, pulse done.
  - Otherwise, if latched gap_ticks=0: stay in TONE, clear hp_cnt, force wave=0.
  - Otherwise: go to GAP, clear gap_cnt, force wave=0.
  - An odd half_periods therefore ends a burst with wave forced low, not left high.
- GAP: wave=0. Each tick event increments gap_cnt. When it equals the latched gap_ticks, go to TONE with hp_cnt cleared.
- stop=1: next cycle is IDLE with wave=0, busy=0 and no done pulse. stop beats start in the same cycle.
- start while busy is ignored. Latched values do not change mid-sequence.
- All counters use equality compares and never wrap within a legal sequence. Total tick events for a sequence = bursts·half_periods + (bursts−1)·gap_ticks.

## Timing
- Reset: state=IDLE, wave=0, busy=0, done=0, tick_q=0, all counters 0. This holds when rst is asserted mid-sequence too.
- Accepted start in cycle t: busy=1 from t+1.
- Tick event in cycle t: wave (and any state change) updates at t+1.
- Final tick event in cycle t: at t+1, done=1, busy=0 and wave=0. At t+2, done=0.
- done is never high in the same cycle as busy.
- The earliest accepted new start is in the cycle where done=1; IDLE has already been entered.
- Single-cycle upstream ticks (count_to match, once per 2^N cycles) are counted one-for-one.

## Test plan
- rst, then start with half_periods=4, bursts=1, gap_ticks=0, tick pulsed every 5 cycles -> wave reads 1,0,1,0, each change 1 cycle after its tick. After the 4th tick: done=1 for one cycle, busy=0 and wave=0 in that same cycle.
- half_periods=3, bursts=3, gap_ticks=2 -> each burst toggles wave 3 times and ends forced low, with a 2-tick silent gap between bursts. done follows the 13th tick event.
- tick held high for 10 cycles during TONE -> exactly one toggle; the next toggle only after tick drops and rises again.
- start with half_periods=0 (and separately bursts=0) -> done pulse next cycle, busy stays 0, wave stays 0.
- stop asserted in TONE with wave=1 -> next cycle wave=0, busy=0, no done. rst asserted mid-GAP -> all outputs 0 next cycle.
- Second start during a busy sequence with different values -> ignored; the original sequence completes with the original tick count. A start in the done cycle is accepted.

Source files
------------

// File: rtl/tone_burst_gen.sv
// Tone-burst square-wave generator: each rising tick edge is one half-period step,
// emitted as a programmable number of bursts separated by silent tick gaps.
module tone_burst_gen #(
  parameter int unsigned W = 16,
  parameter int unsigned R = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         tick_i,
  input  logic         start_i,
  input  logic         stop_i,
  input  logic [W-1:0] half_periods_i,
  input  logic [R-1:0] bursts_i,
  input  logic [W-1:0] gap_ticks_i,
  output logic         wave_o,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic [1:0] {StIdle, StTone, StGap} state_e;

  state_e       state_q, state_d;
  logic         tick_q;
  logic         wave_q, wave_d;
  logic         done_q, done_d;
  logic [W-1:0] hp_lat_q, hp_lat_d;
  logic [R-1:0] bursts_lat_q, bursts_lat_d;
  logic [W-1:0] gap_lat_q, gap_lat_d;
  logic [W-1:0] hp_cnt_q, hp_cnt_d;
  logic [R-1:0] burst_cnt_q, burst_cnt_d;
  logic [W-1:0] gap_cnt_q, gap_cnt_d;

  logic         tick_ev;
  logic [W-1:0] hp_inc;
  logic [R-1:0] burst_inc;
  logic [W-1:0] gap_inc;

  assign tick_ev   = tick_i & ~tick_q;
  assign hp_inc    = hp_cnt_q + 1'b1;
  assign burst_inc = burst_cnt_q + 1'b1;
  assign gap_inc   = gap_cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      tick_q       <= 1'b0;
      wave_q       <= 1'b0;
      done_q       <= 1'b0;
      hp_lat_q     <= '0;
      bursts_lat_q <= '0;
      gap_lat_q    <= '0;
      hp_cnt_q     <= '0;
      burst_cnt_q  <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_i;
      wave_q       <= wave_d;
      done_q       <= done_d;
      hp_lat_q     <= hp_lat_d;
      bursts_lat_q <= bursts_lat_d;
      gap_lat_q    <= gap_lat_d;
      hp_cnt_q     <= hp_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wave_d       = wave_q;
    done_d       = 1'b0;
    hp_lat_d     = hp_lat_q;
    bursts_lat_d = bursts_lat_q;
    gap_lat_d    = gap_lat_q;
    hp_cnt_d     = hp_cnt_q;
    burst_cnt_d  = burst_cnt_q;
    gap_cnt_d    = gap_cnt_q;

    if (stop_i) begin
      state_d = StIdle;
      wave_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          wave_d = 1'b0;
          if (start_i) begin
            if (half_periods_i != '0 && bursts_i != '0) begin
              hp_lat_d     = half_periods_i;
              bursts_lat_d = bursts_i;
              gap_lat_d    = gap_ticks_i;
              hp_cnt_d     = '0;
              burst_cnt_d  = '0;
              gap_cnt_d    = '0;
              state_d      = StTone;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        StTone: begin
          if (tick_ev) begin
            wave_d   = ~wave_q;
            hp_cnt_d = hp_inc;
            if (hp_inc == hp_lat_q) begin
              // Burst ends low regardless of half-period parity.
              wave_d      = 1'b0;
              burst_cnt_d = burst_inc;
              if (burst_inc == bursts_lat_q) begin
                state_d = StIdle;
                done_d  = 1'b1;
              end else if (gap_lat_q == '0) begin
                hp_cnt_d = '0;
              end else begin
                state_d   = StGap;
                gap_cnt_d = '0;
              end
            end
          end
        end
        StGap: begin
          wave_d = 1'b0;
          if (tick_ev) begin
            gap_cnt_d = gap_inc;
            if (gap_inc == gap_lat_q) begin
              state_d  = StTone;
              hp_cnt_d = '0;
            end
          end
        end
        default: begin
          state_d = StIdle;
          wave_d  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    wave_o = wave_q;
    busy_o = (state_q != StIdle);
    done_o = done_q;
  end

endmodule

// File: tb/tb_tone_burst_gen.sv
// Directed bench for tone_burst_gen: table of burst sequences plus hand-written corner cases.
module tb_tone_burst_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        start;
  logic        stop;
  logic [15:0] half_periods;
  logic [3:0]  bursts;
  logic [15:0] gap_ticks;
  logic        wave;
  logic        busy;
  logic        done;

  int tests  = 0;
  int failed = 0;

  tone_burst_gen #(.W(16), .R(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tick_i         (tick),
    .start_i        (start),
    .stop_i         (stop),
    .half_periods_i (half_periods),
    .bursts_i       (bursts),
    .gap_ticks_i    (gap_ticks),
    .wave_o         (wave),
    .busy_o         (busy),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] hp;
    logic [3:0]  nb;
    logic [15:0] gap;
    int          n;        // tick events until done
    logic [15:0] wave_pat; // bit k = wave after tick event k
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] hp, input logic [3:0] nb, input logic [15:0] g);
    @(negedge clk);
    start = 1'b1; half_periods = hp; bursts = nb; gap_ticks = g;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{hp: 16'd4, nb: 4'd1, gap: 16'd0, n: 4,  wave_pat: 16'h0005};
    vecs[1] = '{hp: 16'd3, nb: 4'd3, gap: 16'd2, n: 13, wave_pat: 16'h0421};
    vecs[2] = '{hp: 16'd2, nb: 4'd2, gap: 16'd0, n: 4,  wave_pat: 16'h0005};
    vecs[3] = '{hp: 16'd1, nb: 4'd3, gap: 16'd1, n: 5,  wave_pat: 16'h0000};
    vecs[4] = '{hp: 16'd5, nb: 4'd1, gap: 16'd3, n: 5,  wave_pat: 16'h0005};

    rst = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0;
    half_periods = '0; bursts = '0; gap_ticks = '0;
    repeat (3) @(negedge clk);
    check("reset wave", wave, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      do_start(vecs[v].hp, vecs[v].nb, vecs[v].gap);
      check($sformatf("v%0d busy after start", v), busy, 1);
      check($sformatf("v%0d wave after start", v), wave, 0);
      for (int k = 0; k < vecs[v].n; k++) begin
        repeat (3) @(negedge clk);
        pulse_tick();
        check($sformatf("v%0d wave t%0d", v, k + 1), wave, vecs[v].wave_pat[k]);
        if (k < vecs[v].n - 1) begin
          check($sformatf("v%0d busy t%0d", v, k + 1), busy, 1);
          check($sformatf("v%0d done t%0d", v, k + 1), done, 0);
        end else begin
          check($sformatf("v%0d done final", v), done, 1);
          check($sformatf("v%0d busy final", v), busy, 0);
        end
      end
      @(negedge clk);
      check($sformatf("v%0d done drops", v), done, 0);
    end

    // Held tick counts once; tick coincident with an accepted start is ignored.
    @(negedge clk);
    start = 1'b1; half_periods = 16'd4; bursts = 4'd1; gap_ticks = 16'd0; tick = 1'b1;
    @(negedge clk) start = 1'b0; tick = 1'b0;
    check("tick with start ignored", wave, 0);
    @(negedge clk) tick = 1'b1;
    repeat (10) @(negedge clk);
    check("held tick one toggle", wave, 1);
    tick = 1'b0;
    @(negedge clk);
    check("no toggle on fall", wave, 1);
    pulse_tick();
    check("second toggle", wave, 0);
    pulse_tick();
    pulse_tick();
    check("held seq done", done, 1);
    @(negedge clk);

    // Zero half_periods and zero bursts complete immediately.
    do_start(16'd0, 4'd2, 16'd1);
    check("hp0 done", done, 1);
    check("hp0 busy", busy, 0);
    check("hp0 wave", wave, 0);
    @(negedge clk);
    check("hp0 done drops", done, 0);
    do_start(16'd3, 4'd0, 16'd1);
    check("nb0 done", done, 1);
    check("nb0 busy", busy, 0);

    // Stop in TONE with wave high.
    do_start(16'd4, 4'd2, 16'd1);
    pulse_tick();
    check("pre-stop wave", wave, 1);
    stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    check("stop wave", wave, 0);
    check("stop busy", busy, 0);
    check("stop done", done, 0);
    @(negedge clk);
    check("stop no late done", done, 0);

    // Stop beats start.
    @(negedge clk);
    start = 1'b1; stop = 1'b1; half_periods = 16'd2; bursts = 4'd1;
    @(negedge clk) start = 1'b0; stop = 1'b0;
    check("stop beats start", busy, 0);

    // Reset mid-GAP.
    do_start(16'd1, 4'd2, 16'd3);
    pulse_tick();
    check("in gap busy", busy, 1);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("rst gap busy", busy, 0);
    check("rst gap wave", wave, 0);
    check("rst gap done", done, 0);

    // Start while busy is ignored; start in done cycle is accepted.
    do_start(16'd2, 4'd1, 16'd0);
    pulse_tick();
    do_start(16'd6, 4'd3, 16'd5);
    check("busy start ignored", busy, 1);
    pulse_tick();
    check("orig seq done", done, 1);
    check("orig seq wave", wave, 0);
    start = 1'b1; half_periods = 16'd1; bursts = 4'd1; gap_ticks = 16'd0;
    @(negedge clk) start = 1'b0;
    check("done-cycle start busy", busy, 1);
    check("done-cycle start done", done, 0);
    pulse_tick();
    check("done-cycle seq done", done, 1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time limit reached, expected completion");
    $fatal(1);
  end

endmodule
